// File: rtl/rgb_ycbcr_stream.sv
// rtl/rgb_ycbcr_stream.sv - reads R/G/B frame memories in raster order and streams BT.601 full-range YCbCr
module rgb_ycbcr_stream #(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int AW         = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rdata_r,
    input  logic [7:0]    rdata_g,
    input  logic [7:0]    rdata_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_y,
    output logic [7:0]    out_cb,
    output logic [7:0]    out_cr,
    output logic          out_last,
    output logic          done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
    localparam int            PW        = $clog2(FIFO_DEPTH);
    localparam int            CW        = PW + 1;
    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            v1_q, v2_q, v3_q;
    logic            l1_q, l2_q, l3_q;
    logic [7:0]      r_q, g_q, b_q;
    logic [17:0]     ys_q, cbs_q, crs_q;
    logic [24:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push, pop, issue;
    logic [CW:0]     occ;
    logic [24:0]     head, push_data;

    function automatic logic [7:0] sat8(input logic [17:0] v);
        return (v > 18'd255) ? 8'hFF : v[7:0];
    endfunction

    // The entry popped this cycle frees its slot now, which is what lets
    // three in-flight reads plus one FIFO entry sustain a pixel per cycle.
    always_comb begin
        pop   = (count_q != '0) && out_ready;
        occ   = {1'b0, count_q} + {{CW{1'b0}}, v1_q} + {{CW{1'b0}}, v2_q}
              + {{CW{1'b0}}, v3_q} - {{CW{1'b0}}, pop};
        issue = (state_q == RUN) && (occ < DEPTH_C);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (addr_q == LAST_ADDR) state_d = DRAIN;
                    else                     addr_d  = addr_q + AW'(1);
                end
            end
            DRAIN: begin
                if (!v1_q && !v2_q && !v3_q && count_q == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign rd_en   = issue;
    assign rd_addr = addr_q;
    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

    // S1 captures memory data, S2 registers the fixed-point sums.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            l1_q  <= 1'b0;
            l2_q  <= 1'b0;
            l3_q  <= 1'b0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            ys_q  <= '0;
            cbs_q <= '0;
            crs_q <= '0;
        end else begin
            v1_q  <= issue;
            l1_q  <= issue && (addr_q == LAST_ADDR);
            v2_q  <= v1_q;
            l2_q  <= l1_q;
            v3_q  <= v2_q;
            l3_q  <= l2_q;
            r_q   <= rdata_r;
            g_q   <= rdata_g;
            b_q   <= rdata_b;
            ys_q  <= 18'd77 * {10'd0, r_q} + 18'd150 * {10'd0, g_q}
                   + 18'd29 * {10'd0, b_q} + 18'd128;
            cbs_q <= 18'd32896 + 18'd128 * {10'd0, b_q}
                   - 18'd43 * {10'd0, r_q} - 18'd85 * {10'd0, g_q};
            crs_q <= 18'd32896 + 18'd128 * {10'd0, r_q}
                   - 18'd107 * {10'd0, g_q} - 18'd21 * {10'd0, b_q};
        end
    end

    // S3: chroma sums can land exactly on 65536, hence the saturation.
    always_comb begin
        push      = v3_q;
        push_data = {l3_q, sat8(ys_q >> 8), sat8(cbs_q >> 8), sat8(crs_q >> 8)};
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = (count_q != '0);
        out_last  = out_valid & head[24];
        out_y     = out_valid ? head[23:16] : 8'd0;
        out_cb    = out_valid ? head[15:8]  : 8'd0;
        out_cr    = out_valid ? head[7:0]   : 8'd0;
    end

endmodule

// File: tb/tb_rgb_ycbcr_stream.sv
// tb/tb_rgb_ycbcr_stream.sv - scoreboard bench for rgb_ycbcr_stream
module tb_rgb_ycbcr_stream;
    localparam int N     = 16384;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, start, busy, rd_en;
    logic [13:0] rd_addr;
    logic [7:0]  rdata_r = 8'd0, rdata_g = 8'd0, rdata_b = 8'd0;
    logic        out_valid, out_ready, out_last, done;
    logic [7:0]  out_y, out_cb, out_cr;

    always #5 clk = ~clk;

    rgb_ycbcr_stream dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
        .out_last(out_last), .done(done)
    );

    logic [7:0] mem_r [N];
    logic [7:0] mem_g [N];
    logic [7:0] mem_b [N];

    always @(posedge clk) begin
        if (rd_en) begin
            rdata_r <= mem_r[rd_addr];
            rdata_g <= mem_g[rd_addr];
            rdata_b <= mem_b[rd_addr];
        end
    end

    int n_chk = 0, n_fail = 0, cyc = 0;
    int exp_addr, outs, xfers, lasts, done_cnt, stalls, first_rd, first_ov, ready_mode;
    bit frame_done, prev_hold;
    logic [24:0] prev_out, e;
    logic [24:0] exp_q [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [24:0] golden(input int idx);
        int r, g, b, y, cb, cr;
        r  = int'(mem_r[idx]);
        g  = int'(mem_g[idx]);
        b  = int'(mem_b[idx]);
        y  = (77 * r + 150 * g + 29 * b + 128) / 256;
        cb = (32896 + 128 * b - 43 * r - 85 * g) / 256;
        cr = (32896 + 128 * r - 107 * g - 21 * b) / 256;
        if (cb > 255) cb = 255;
        if (cr > 255) cr = 255;
        return {idx == N - 1, 8'(y), 8'(cb), 8'(cr)};
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) begin
                chk("rd_addr", int'(rd_addr), exp_addr);
                exp_addr++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (busy && !rd_en && exp_addr > 0 && exp_addr < N) stalls++;
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (prev_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'({out_last, out_y, out_cb, out_cr}), int'(prev_out));
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {out_last, out_y, out_cb, out_cr};
            if (out_valid && out_ready) begin
                xfers++;
                if (out_last) lasts++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got 0x%0h expected none", prev_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", int'({out_last, out_y, out_cb, out_cr}), int'(e));
                end
            end
            outs = outs + int'(rd_en) - int'(out_valid && out_ready);
            if (rd_en) chk("outstanding_le_4", int'(outs <= DEPTH), 1);
            if (done) begin
                done_cnt++;
                chk("done_xfers", xfers, N);
                chk("done_lasts", lasts, 1);
                chk("done_queue_empty", exp_q.size(), 0);
                frame_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'({out_last, out_y, out_cb, out_cr}), 0);
        chk("rst_done", int'(done), 0);
    endtask

    task automatic begin_frame();
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(golden(i));
        exp_addr   = 0;
        xfers      = 0;
        lasts      = 0;
        stalls     = 0;
        first_rd   = -1;
        first_ov   = -1;
        frame_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !frame_done; i++) tick();
        chk("frame_done_in_time", int'(frame_done), 1);
        tick();
        chk("busy_after_done", int'(busy), 0);
    endtask

    int d0;

    initial begin
        reset = 1'b1; start = 1'b0; ready_mode = 0; out_ready = 1'b1;
        outs = 0; done_cnt = 0; prev_hold = 1'b0; exp_addr = 0;
        xfers = 0; lasts = 0; stalls = 0; first_rd = -1; first_ov = -1;
        for (int i = 0; i < N; i++) begin
            mem_r[i] = 8'd0; mem_g[i] = 8'd0; mem_b[i] = 8'd0;
        end
        mem_r[0] = 8'd255;
        mem_b[1] = 8'd255;
        mem_r[2] = 8'd255; mem_g[2] = 8'd255; mem_b[2] = 8'd255;
        repeat (3) tick();
        check_reset_state();
        reset = 1'b0;
        tick();

        // Frame A: directed pixels 0..2, remainder zero, ready held high
        chk("golden_pix0", int'(golden(0)), int'({1'b0, 8'd77, 8'd85, 8'd255}));
        chk("golden_pix1", int'(golden(1)), int'({1'b0, 8'd29, 8'd255, 8'd107}));
        chk("golden_pix2", int'(golden(2)), int'({1'b0, 8'd255, 8'd128, 8'd128}));
        chk("golden_zero", int'(golden(N - 1)), int'({1'b1, 8'd0, 8'd128, 8'd128}));
        begin_frame();
        wait_done(20000);
        chk("first_latency", first_ov - first_rd, 4);

        // Frame B: random data, random ready, one long stall mid-frame
        for (int i = 0; i < N; i++) begin
            mem_r[i] = 8'($urandom); mem_g[i] = 8'($urandom); mem_b[i] = 8'($urandom);
        end
        ready_mode = 1;
        begin_frame();
        repeat (3000) tick();
        ready_mode = 2;
        repeat (22) tick();
        ready_mode = 1;
        wait_done(45000);
        chk("stalls_seen", int'(stalls > 0), 1);
        ready_mode = 0;

        // Frame C: abort by reset mid-run, then a clean frame with a stray start
        begin_frame();
        repeat (300) tick();
        reset = 1'b1;
        tick();
        tick();
        check_reset_state();
        d0 = done_cnt;
        exp_q.delete();
        outs = 0;
        prev_hold = 1'b0;
        reset = 1'b0;
        repeat (6) tick();
        chk("no_done_after_abort", done_cnt, d0);
        begin_frame();
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20000);
        chk("done_count", done_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_ycbcr_stream.md
Name: rgb_ycbcr_stream

Overview:
- Downstream stage of the Bayer demosaic block.
- After demosaic signals done, this block reads the completed R, G and B frame memories pixel by pixel in raster order.
- Each pixel is converted to 8-bit YCbCr (BT.601 full-range, fixed point) and streamed out on a valid/ready interface, with last and done markers.
- A small output FIFO absorbs backpressure caused by the 1-cycle memory read latency.

Parameters:
- IMG_W, 128, pixels per row (power of 2)
- IMG_H, 128, rows per frame
- AW, 14, read address width, log2(IMG_W*IMG_H)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, tied to demosaic done; begins a frame
- busy  out  1  high from the cycle after an accepted start until done
- rd_en  out  1  read strobe to the R/G/B memories
- rd_addr  out  AW  shared read address; row*IMG_W+col
- rdata_r  in  8  R memory data; valid 1 cycle after rd_en
- rdata_g  in  8  G memory data; valid 1 cycle after rd_en
- rdata_b  in  8  B memory data; valid 1 cycle after rd_en
- out_valid  out  1  output pixel valid
- out_ready  in  1  consumer ready
- out_y  out  8  luma
- out_cb  out  8  blue-difference chroma
- out_cr  out  8  red-difference chroma
- out_last  out  1  high with the final pixel of the frame (addr IMG_W*IMG_H-1)
- done  out  1  one-cycle pulse after the last pixel handshakes

Behaviour:
- Reset values: all outputs 0, rd_addr 0, FIFO empty, state IDLE. Reset mid-frame aborts immediately; no done pulse is produced.
- Memory latency: rd_en with rd_addr in cycle t; rdata_* sampled in cycle t+1.
- Pipeline:
  - S0: issue read.
  - S1: capture rdata.
  - S2: register three 18-bit products-sums.
  - S3: shift, clamp, push into FIFO.
- Latency: first rd_en to out_valid is 4 cycles when out_ready=1.
- Throughput: 1 pixel/cycle sustained with out_ready held high.
- Issue rule: rd_en=1 only when fifo_count + inflight < FIFO_DEPTH, where inflight = reads in S1..S3. The FIFO never overflows, and no data is dropped under any out_ready pattern.
- Handshake:
  - out_y/cb/cr/last reflect the FIFO head.
  - A transfer occurs when out_valid & out_ready.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Arithmetic (unsigned, integer):
  - Y = (77R + 150G + 29B + 128) >> 8
  - Cb = (32896 + 128B - 43R - 85G) >> 8
  - Cr = (32896 + 128R - 107G - 21B) >> 8
  - Intermediates are never negative. Cb and Cr can reach 256 and clamp to 255. Y never exceeds 255.
- FSM:
  - IDLE: on start -> RUN; rd_addr=0, busy=1. A start arriving in any other state is ignored.
  - RUN: issue reads per the issue rule, incrementing rd_addr. When the final address (IMG_W*IMG_H-1) is issued -> DRAIN. rd_addr does not wrap past the last address.
  - DRAIN: no reads; wait until the pipeline and FIFO are empty and the last-flagged pixel has transferred -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Simultaneous push and pop on the FIFO: count is unchanged. Pop from an empty FIFO is impossible because out_valid=0.
- Exactly IMG_W*IMG_H transfers occur per frame, and out_last is asserted on exactly one of them.

Test Plan:
- Memories all 0, out_ready=1, start -> every pixel Y=0 Cb=128 Cr=128; first out_valid 4 cycles after first rd_en; done pulse after 16384 transfers.
- Pixel 0 R=255 G=0 B=0 -> Y=77 Cb=85 Cr=255 (clamped from 256).
- Pixel 1 R=0 G=0 B=255 -> Y=29 Cb=255 Cr=107. Pixel 2 R=G=B=255 -> Y=255 Cb=128 Cr=128.
- Random frame with random out_ready (50%) -> output sequence matches the golden model in raster order; rd_en stalls when FIFO plus inflight reaches 4; no loss or duplication; out_last only on pixel 16383.
- out_ready=0 for 20 cycles mid-frame -> out_* stable throughout; at most 4 reads outstanding; the stream resumes with the correct next pixel.
- Reset asserted mid-RUN, then a second start -> no done from the aborted frame; the new frame restarts at rd_addr 0 and completes correctly. A start pulse during RUN is ignored.
